// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache, 4-word blocks, busywait refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct_mapped #(
    parameter  int INDEX_BITS = 3,
    localparam int TAG_BITS   = 28 - INDEX_BITS,
    localparam int NBLK       = 1 << INDEX_BITS
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
`ifdef ICACHE_STATS_EN
    input  logic         mem_busywait,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`else
    input  logic         mem_busywait
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    state_t state_q, state_d;

    logic [NBLK-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_q  [NBLK];
    logic [127:0]        data_q [NBLK];
    logic [27:0]         miss_addr_q, miss_addr_d;
    logic [31:0]         instr_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag_in;
    logic [1:0]            off;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  hit;
    logic                  idle_hit;
    logic                  fill;
    logic [31:0]           word;
    logic                  unused_addr;

    assign idx         = address[4 +: INDEX_BITS];
    assign tag_in      = address[31 -: TAG_BITS];
    assign off         = address[3:2];
    assign miss_idx    = miss_addr_q[INDEX_BITS-1:0];
    assign miss_tag    = miss_addr_q[27 -: TAG_BITS];
    assign unused_addr = ^address[1:0];

    assign hit      = valid_q[idx] && (tag_q[idx] == tag_in);
    assign word     = data_q[idx][{off, 5'b00000} +: 32];
    assign idle_hit = (state_q == IDLE) && hit;

    assign mem_address = miss_addr_q;
    // Outside a hit, keep presenting the last word handed to the core.
    assign instruction = idle_hit ? word : instr_q;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        busywait    = 1'b1;
        mem_read    = 1'b0;
        fill        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    busywait = 1'b0;
                end else begin
                    miss_addr_d = address[31:4];
                    state_d     = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                fill    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
            end
            if (idle_hit) begin
                instr_q <= word;
            end
        end
    end

    // Arrays are qualified by valid_q, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_q[miss_idx] <= mem_readdata;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped with a latency-programmable memory.
// Expected words and stalls come from an abstract valid/tag model of the cache.
module tb_icache_direct_mapped;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [31:0]  address = '0;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    icache_direct_mapped dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
`ifdef ICACHE_STATS_EN
        .mem_busywait (mem_busywait),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`else
        .mem_busywait (mem_busywait)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          stall;
    } exp_t;

    exp_t        exp_q[$];
    logic [27:0] fill_q[$];
    int errors = 0;
    int checks = 0;
    int done   = 0;
    int stall  = 0;
    int lat    = 3;
    int mcnt   = 0;
    logic prev_mr = 1'b0;
    exp_t        mon_e;
    logic [27:0] mon_f;

    logic        valid_m [8];
    logic [24:0] tag_m   [8];
    int m_hits = 0;
    int m_miss = 0;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'd1;
    endfunction

    // Memory: busy for lat cycles of mem_read, data served from mem_address.
    always @(negedge CLK) begin
        if (mem_read) begin
            mcnt = mcnt + 1;
            mem_busywait = (mcnt < lat);
            for (int i = 0; i < 4; i++)
                mem_readdata[32*i +: 32] = mword({mem_address, 4'b0000} + 32'(4 * i));
        end else begin
            mcnt = 0;
            mem_busywait = 1'b0;
        end
    end

    // Monitor: refill starts against fill_q, delivered words against exp_q.
    always @(negedge CLK) begin
        if (RESET) begin
            stall   = 0;
            prev_mr = 1'b0;
        end else begin
            if (mem_read && !prev_mr) begin
                checks++;
                if (fill_q.size() == 0) begin
                    errors++;
                    $display("FAIL refill_unexpected got=%h want=none", mem_address);
                end else begin
                    mon_f = fill_q.pop_front();
                    if (mem_address !== mon_f) begin
                        errors++;
                        $display("FAIL refill_addr got=%h want=%h", mem_address, mon_f);
                    end
                end
            end
            prev_mr = mem_read;
            if (exp_q.size() > 0) begin
                if (busywait) begin
                    stall++;
                end else begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    if (instruction !== mword(mon_e.addr)) begin
                        errors++;
                        $display("FAIL instr addr=%h got=%h want=%h",
                                 mon_e.addr, instruction, mword(mon_e.addr));
                    end
                    if (mon_e.stall >= 0) begin
                        checks++;
                        if (stall != mon_e.stall) begin
                            errors++;
                            $display("FAIL stall addr=%h got=%0d want=%0d",
                                     mon_e.addr, stall, mon_e.stall);
                        end
                    end
                    stall = 0;
                    done++;
                end
            end
        end
    end

    task automatic wait_done(input int tgt);
        int n = 0;
        while (done < tgt && n < 200) begin
            @(posedge CLK);
            n++;
        end
        checks++;
        if (done < tgt) begin
            errors++;
            $display("FAIL timeout got=%0d want=%0d", done, tgt);
        end
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input int l);
        exp_t e;
        logic [2:0] idx;
        bit h;
        int tgt;
        tgt = done + 1;
        idx = a[6:4];
        h = valid_m[idx] && (tag_m[idx] == a[31:7]);
        lat = l;
        e.addr  = a;
        e.stall = h ? 0 : l + 2;
        m_hits++;
        if (!h) begin
            m_miss++;
            fill_q.push_back(a[31:4]);
            valid_m[idx] = 1'b1;
            tag_m[idx]   = a[31:7];
        end
        exp_q.push_back(e);
        address = a;
        wait_done(tgt);
    endtask

    task automatic check1(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Ends with RESET released at posedge+1; caller drives the next fetch at once.
    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        exp_q.delete();
        fill_q.delete();
        for (int i = 0; i < 8; i++) valid_m[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
        RESET = 1'b0;
    endtask

    initial begin
        exp_t e;
        int tgt;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            valid_m[i] = 1'b0;
            tag_m[i]   = '0;
        end
        repeat (2) @(posedge CLK);
        #1;
        check1("rst_instr", instruction, 32'h0);
        check1("rst_busy", {31'b0, busywait}, 32'h1);
        check1("rst_memread", {31'b0, mem_read}, 32'h0);
        check1("rst_memaddr", {4'b0, mem_address}, 32'h0);
        do_reset();

        fetch(32'h0000_0000, 5);
        fetch(32'h0000_0004, 5);
        fetch(32'h0000_0008, 5);
        fetch(32'h0000_000C, 5);
`ifdef ICACHE_STATS_EN
        check1("hit_count", hit_count, 32'(m_hits));
        check1("miss_count", miss_count, 32'(m_miss));
`endif

        fetch(32'h0000_0080, 4);
        fetch(32'h0000_0000, 3);
        fetch(32'h0000_0084, 2);

        // Reset during the third MEM_READ cycle of a refill.
        lat = 5;
        fill_q.push_back(28'h000_0002);
        address = 32'h0000_0020;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        check1("midrst_memread", {31'b0, mem_read}, 32'h0);
        check1("midrst_busy", {31'b0, busywait}, 32'h1);
        check1("midrst_instr", instruction, 32'h0);
        do_reset();
        fetch(32'h0000_0020, 5);

        // Address moves 0x10 -> 0x40 while block 0x1 is being filled.
        lat = 5;
        fill_q.push_back(28'h000_0001);
        valid_m[1] = 1'b1;
        tag_m[1]   = '0;
        address = 32'h0000_0010;
        repeat (2) @(posedge CLK);
        #1;
        tgt = done + 1;
        e.addr  = 32'h0000_0040;
        e.stall = -1;
        exp_q.push_back(e);
        fill_q.push_back(28'h000_0004);
        valid_m[4] = 1'b1;
        tag_m[4]   = '0;
        address = 32'h0000_0040;
        wait_done(tgt);
        fetch(32'h0000_0010, 3);
        fetch(32'h0000_001C, 3);

        fetch(32'hFFFF_FFFC, 2);
        fetch(32'hFFFF_FFF0, 1);

        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(0, 3)) << 7)
              | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2)
              | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a | 32'hFFFF_FF80;
            fetch(a, int'($urandom_range(1, 6)));
        end

        repeat (2) @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_left got=%0d want=0", exp_q.size());
        end
        checks++;
        if (fill_q.size() != 0) begin
            errors++;
            $display("FAIL fill_left got=%0d want=0", fill_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
